// File: rtl/bf16_fma_vector_engine.sv
// bf16_fma_vector_engine
// Self-running stimulus/response checker for a combinational bfloat16 FMA
// (result = A*B + C, plus overflow flag). A host loads {A,B,C,exp_res,exp_ov}
// vectors into local storage. Each start then replays num_vec of them through
// the FMA and compares the results bit-exactly against the expected values.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cfg_we_i/addr_i/wdata_i host write of one vector slot (dropped while busy)
//   num_vec_i, start_i     run length (clamped to DEPTH) and start pulse
//   fma_a_o/b_o/c_o        registered operands to the FMA
//   fma_result_i, fma_ov_i FMA response
//   busy_o, done_o, pass_o run status
//   err_count_o            saturating mismatch count
//   first_fail_idx_o/res_o slot index and {result,ov} of the first mismatch
module bf16_fma_vector_engine #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CW     = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cfg_we_i,
  input  logic [AW-1:0] cfg_addr_i,
  input  logic [64:0]   cfg_wdata_i,
  input  logic [AW:0]   num_vec_i,
  input  logic          start_i,
  output logic [15:0]   fma_a_o,
  output logic [15:0]   fma_b_o,
  output logic [15:0]   fma_c_o,
  input  logic [15:0]   fma_result_i,
  input  logic          fma_ov_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          pass_o,
  output logic [CW-1:0] err_count_o,
  output logic [AW-1:0] first_fail_idx_o,
  output logic [16:0]   first_fail_res_o
);

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StCheck, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   num_q, num_d;
  logic [SW-1:0] wcnt_q, wcnt_d;
  logic [15:0]   a_q, a_d, b_q, b_d, c_q, c_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [CW-1:0] err_q, err_d;
  logic [AW-1:0] ff_idx_q, ff_idx_d;
  logic [16:0]   ff_res_q, ff_res_d;

  logic [64:0]   mem_q [DEPTH];
  logic [64:0]   vec;
  logic          start_acc, cfg_wr, mismatch, last_vec;
  logic [AW:0]   num_clamped;

  // Start and host writes are only honoured while no run is in flight.
  assign start_acc   = start_i && !busy_q;
  assign cfg_wr      = cfg_we_i && !busy_q;
  assign vec         = mem_q[idx_q];
  assign mismatch    = ({fma_result_i, fma_ov_i} != vec[16:0]);
  assign last_vec    = ({1'b0, idx_q} == (num_q - 1'b1));
  assign num_clamped = (num_vec_i > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec_i;

  // Vector storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (cfg_wr) begin
      mem_q[cfg_addr_i] <= cfg_wdata_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    num_d    = num_q;
    wcnt_d   = wcnt_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    ff_idx_d = ff_idx_q;
    ff_res_d = ff_res_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_acc) begin
          err_d    = '0;
          ff_idx_d = '0;
          ff_res_d = '0;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          idx_d    = '0;
          num_d    = num_clamped;
          state_d  = (num_clamped == '0) ? StDone : StIssue;
        end else if (state_q == StDone && busy_q) begin
          // done lags entry to StDone by one cycle so the final error
          // update is already visible when done rises.
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      StIssue: begin
        a_d     = vec[64:49];
        b_d     = vec[48:33];
        c_d     = vec[32:17];
        wcnt_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (wcnt_q == SW'(SETTLE - 1)) begin
          state_d = StCheck;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      StCheck: begin
        if (mismatch) begin
          if (err_q != '1) begin
            err_d = err_q + 1'b1;
          end
          if (err_q == '0) begin
            ff_idx_d = idx_q;
            ff_res_d = {fma_result_i, fma_ov_i};
          end
        end
        if (last_vec) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      num_q    <= '0;
      wcnt_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= '0;
      ff_idx_q <= '0;
      ff_res_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      wcnt_q   <= wcnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ff_idx_q <= ff_idx_d;
      ff_res_q <= ff_res_d;
    end
  end

  assign fma_a_o          = a_q;
  assign fma_b_o          = b_q;
  assign fma_c_o          = c_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = done_q && (err_q == '0);
  assign err_count_o      = err_q;
  assign first_fail_idx_o = ff_idx_q;
  assign first_fail_res_o = ff_res_q;

endmodule

// File: tb/tb_bf16_fma_vector_engine.sv
// Directed bench for bf16_fma_vector_engine. Two instances share host inputs:
// u_dut (CW=8) and u_sat (CW=2, for saturation). Each drives its own FMA
// stand-in: a table of hand-computed bf16 FMA results, XOR of operands otherwise.
module tb_bf16_fma_vector_engine;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned PER    = SETTLE + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [64:0] cfg_wdata = '0;
  logic [4:0]  num_vec = '0;
  logic        start = 1'b0;

  logic [15:0] a1, b1, c1, res1, a2, b2, c2, res2;
  logic        ov1, ov2, busy1, done1, pass1, busy2, done2, pass2;
  logic [7:0]  err1;
  logic [1:0]  err2;
  logic [3:0]  fidx1, fidx2;
  logic [16:0] fres1, fres2;

  int checks = 0;
  int failures = 0;
  int cyc;

  always #5 clk = ~clk;

  function automatic logic [16:0] fma_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c);
    logic [47:0] key;
    key = {a, b, c};
    case (key)
      48'h4160_41C0_41E0: return {16'h43B6, 1'b0};  // 14*24+28 = 364
      48'h3F80_3F80_3F80: return {16'h4000, 1'b0};  // 1*1+1 = 2
      48'h4000_4040_3F80: return {16'h40E0, 1'b0};  // 2*3+1 = 7
      48'h7F7F_7F7F_0000: return {16'h7F80, 1'b1};  // max*max -> +inf, ov
      default:            return {a ^ b ^ c, 1'b0};
    endcase
  endfunction

  assign {res1, ov1} = fma_model(a1, b1, c1);
  assign {res2, ov2} = fma_model(a2, b2, c2);

  bf16_fma_vector_engine #(.DEPTH(16), .AW(4), .SETTLE(SETTLE), .CW(8)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
    .cfg_wdata_i(cfg_wdata), .num_vec_i(num_vec), .start_i(start),
    .fma_a_o(a1), .fma_b_o(b1), .fma_c_o(c1), .fma_result_i(res1), .fma_ov_i(ov1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(err1),
    .first_fail_idx_o(fidx1), .first_fail_res_o(fres1)
  );

  bf16_fma_vector_engine #(.DEPTH(16), .AW(4), .SETTLE(SETTLE), .CW(2)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
    .cfg_wdata_i(cfg_wdata), .num_vec_i(num_vec), .start_i(start),
    .fma_a_o(a2), .fma_b_o(b2), .fma_c_o(c2), .fma_result_i(res2), .fma_ov_i(ov2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_count_o(err2),
    .first_fail_idx_o(fidx2), .first_fail_res_o(fres2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] slot_ops(input int i);
    case (i)
      0:       return 48'h4160_41C0_41E0;
      1:       return 48'h3F80_3F80_3F80;
      2:       return 48'h4000_4040_3F80;
      3:       return 48'h7F7F_7F7F_0000;
      default: return {16'(16'h3F80 + i), 16'(16'h4000 + i), 16'(16'h0100 * i)};
    endcase
  endfunction

  function automatic logic [16:0] slot_res(input int i);
    logic [47:0] o;
    o = slot_ops(i);
    return fma_model(o[47:32], o[31:16], o[15:0]);
  endfunction

  // bad flips the LSB of the expected result.
  task automatic wr(input int i, input logic bad);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = 4'(i);
    cfg_wdata = {slot_ops(i), slot_res(i) ^ (bad ? 17'h2 : 17'h0)};
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic kick(input int n);
    @(negedge clk);
    num_vec = 5'(n);
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after the start-sample edge until done, bounded.
  task automatic wait_done(input int already, input int exp_cyc, input string tag);
    cyc = already;
    while (!done1 && cyc < 300) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk(tag, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_pass", 32'(pass1), 32'd0);
    chk("rst_err", 32'(err1), 32'd0);
    chk("rst_fidx", 32'(fidx1), 32'd0);
    chk("rst_fres", 32'(fres1), 32'd0);
    chk("rst_fma_a", 32'(a1), 32'd0);
    rst_n = 1'b1;

    // 1) single good vector
    wr(0, 1'b0);
    kick(1);
    chk("t1_busy", 32'(busy1), 32'd1);
    wait_done(0, PER + 1, "t1_latency");
    chk("t1_pass", 32'(pass1), 32'd1);
    chk("t1_err", 32'(err1), 32'd0);
    chk("t1_busy_low", 32'(busy1), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("t1_fma_a_hold", 32'(a1), 32'h4160);
    chk("t1_fma_c_hold", 32'(c1), 32'h41E0);

    // 2) same slot, wrong expected result; restart from DONE
    wr(0, 1'b1);
    kick(1);
    chk("t2_done_cleared", 32'(done1), 32'd0);
    wait_done(0, PER + 1, "t2_latency");
    chk("t2_pass", 32'(pass1), 32'd0);
    chk("t2_err", 32'(err1), 32'd1);
    chk("t2_fidx", 32'(fidx1), 32'd0);
    chk("t2_fres", 32'(fres1), 32'h876C);

    // 3) 16 slots, 5 and 9 bad
    for (int i = 0; i < 16; i++) wr(i, (i == 5) || (i == 9));
    kick(16);
    wait_done(0, 16 * PER + 1, "t3_latency");
    chk("t3_err", 32'(err1), 32'd2);
    chk("t3_fidx", 32'(fidx1), 32'd5);
    chk("t3_fres", 32'(fres1), 32'(slot_res(5)));
    chk("t3_pass", 32'(pass1), 32'd0);

    // 4) five bad vectors: CW=2 saturates at 3; then an empty run
    for (int i = 0; i < 5; i++) wr(i, 1'b1);
    kick(5);
    wait_done(0, 5 * PER + 1, "t4_latency");
    chk("t4_err_cw8", 32'(err1), 32'd5);
    chk("t4_err_cw2_sat", 32'(err2), 32'd3);
    chk("t4_fidx_cw2", 32'(fidx2), 32'd0);
    chk("t4_fres", 32'(fres1), 32'h876C);
    kick(0);
    wait_done(0, 1, "t4_empty_latency");
    chk("t4_empty_pass", 32'(pass1), 32'd1);
    chk("t4_empty_err_cw2", 32'(err2), 32'd0);
    chk("t4_empty_pass_cw2", 32'(pass2), 32'd1);
    for (int i = 0; i < 5; i++) wr(i, 1'b0);

    // num_vec above DEPTH clamps to 16
    kick(20);
    wait_done(0, 16 * PER + 1, "clamp_latency");
    chk("clamp_err", 32'(err1), 32'd2);

    // 5) reset during vector 3 of 8
    kick(8);
    repeat (3 * PER + 1) @(posedge clk);
    #1 chk("t5_busy_before", 32'(busy1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 32'(busy1), 32'd0);
    chk("t5_done", 32'(done1), 32'd0);
    chk("t5_err", 32'(err1), 32'd0);
    chk("t5_fma_a", 32'(a1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    kick(8);
    wait_done(0, 8 * PER + 1, "t5_rerun_latency");
    chk("t5_rerun_err", 32'(err1), 32'd1);
    chk("t5_rerun_fidx", 32'(fidx1), 32'd5);

    // 6) cfg_we and start while busy are dropped
    kick(16);
    repeat (10) @(posedge clk);
    #1;
    cfg_we    = 1'b1;
    cfg_addr  = 4'd5;
    cfg_wdata = {slot_ops(5), slot_res(5)};
    start     = 1'b1;
    num_vec   = 5'd1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    start  = 1'b0;
    wait_done(11, 16 * PER + 1, "t6_latency");
    chk("t6_err", 32'(err1), 32'd2);
    chk("t6_fidx", 32'(fidx1), 32'd5);
    kick(16);
    wait_done(0, 16 * PER + 1, "t6_rerun_latency");
    chk("t6_mem_kept_err", 32'(err1), 32'd2);
    chk("t6_mem_kept_fidx", 32'(fidx1), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
